huffman_feed_ctrl: RTL and testbench
====================================

# huffman_feed_ctrl

Sequencer that feeds a packed bitstream into the Huffman decoder and collects a requested number of decoded symbols. It accepts WORD_W-bit words over a valid/ready handshake, resets the decoder at job start, and serializes each word MSB-first onto the decoder's bit input. It forwards each decoded symbol, stops after `sym_count` symbols, and aborts on invalid or overlong codes. It sits between the stream source and the decoder core (`bit_in`/`symbol_out`/`valid_out`).

## Interface
- WORD_W, 8, input word width; bits issued MSB-first
- SYM_W, 5, decoder symbol width
- CNT_W, 8, width of symbol-count request/counter
- MAX_BITS, 17, max bits issued without a decoded symbol before abort
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  job start pulse; sampled only in IDLE
- sym_count  input  CNT_W  symbols to decode; sampled with start
- in_data  input  WORD_W  packed stream word
- in_valid  input  1  in_data valid
- in_ready  output  1  word accepted when in_valid && in_ready
- dec_rst  output  1  decoder reset, drives decoder `rst`
- dec_bit  output  1  serial bit, drives decoder `bit_in`
- dec_bit_vld  output  1  dec_bit is a live stream bit this cycle
- dec_sym  input  SYM_W  decoder `symbol_out`
- dec_valid  input  1  decoder `valid_out`
- sym_out  output  SYM_W  forwarded symbol
- sym_valid  output  1  sym_out valid, one-cycle pulse per symbol
- busy  output  1  job in progress
- done  output  1  one-cycle job-end pulse (success or abort)
- err  output  2  0 none, 1 symbol out of range, 2 code too long; held until next accepted start

## Operation
- Reset values: in_ready=0, dec_rst=1, dec_bit=0, dec_bit_vld=0, sym_out=0, sym_valid=0, busy=0, done=0, err=0. dec_rst drops to 0 in the first cycle after rst deasserts.
- States: IDLE, DRST, FETCH, SHIFT.
- IDLE -> DRST on start with sym_count!=0. Action: err cleared, busy=1, dec_rst=1 for exactly one cycle.
- start with sym_count==0: no decoder reset; next cycle done=1, err=0, busy stays 0.
- DRST -> FETCH unconditionally.
- FETCH: in_ready=1. On handshake, load the shift register -> SHIFT.
- SHIFT: dec_bit_vld=1, dec_bit=shift-reg MSB. Shift left each cycle.
  - in_ready=1 only on the last bit (bit_idx==WORD_W-1). Handshake then reloads and stays in SHIFT, giving gapless bits. Otherwise -> FETCH.
- Symbols are counted on dec_valid in DRST/FETCH/SHIFT and ignored in IDLE.
- Each counted symbol is registered to sym_out/sym_valid one cycle later.
- bits_since counter:
  - +1 per issued bit, saturating at MAX_BITS+1.
  - Cleared on dec_valid; dec_valid wins over a same-cycle issued bit.
- Termination is evaluated in priority order:
  1. Out-of-range symbol (outside 1..18) -> abort, err=1, symbol not forwarded.
  2. Symbol count reaches sym_count -> success.
  3. bits_since reaches MAX_BITS+1 -> abort, err=2.
- On any termination: next cycle done=1, busy=0, state IDLE, in_ready=0, dec_bit_vld=0. Unissued bits of the current word are discarded.
- Stalls in FETCH do not advance bits_since.
- rst mid-job: all state to reset values at that edge; the in-flight word and count are discarded, with no done pulse.

## Timing
- Cycle 0 start -> cycle 1 DRST (dec_rst=1, busy=1) -> cycle 2 FETCH (in_ready=1).
- in_valid at cycle 2 -> first bit on cycle 3; WORD_W bits on cycles 3..WORD_W+2.
- Symbol latency: dec_valid at cycle t -> sym_valid at t+1.
- The final symbol's sym_valid coincides with done.
- Back-to-back words: zero bubble cycles when in_valid is high on the last-bit cycle.

## Configuration
- HUFF_FEED_SYMCHK_EN defined: range check 1..18 active, err=1 abort as above.
- HUFF_FEED_SYMCHK_EN undefined: no check; every dec_valid symbol is forwarded and counted, and err is never 1.

## Structure
- Shared package huffman_pkg holds:
  - SYM_W, SYM_MIN=1, SYM_MAX=18
  - state enum (IDLE, DRST, FETCH, SHIFT)
  - err enum (ERR_NONE, ERR_RANGE, ERR_LEN)
- Sub-module huffman_bit_serializer holds the shift register, bit_idx, in_ready and dec_bit/dec_bit_vld generation, with load/last-bit handshake to the FSM.

## Test plan
- sym_count=3, stream 8'b0101_1000 for a 3-symbol decode -> one dec_rst pulse at cycle 1, bits 0,1,0,1,1,0,0,0 on cycles 3..10, three sym_valid pulses, done with err=0, busy low after.
- Two words with in_valid held -> 16 contiguous dec_bit_vld cycles, in_ready high only on cycles 10 and 18.
- in_valid withheld 5 cycles mid-job -> dec_bit_vld low throughout, no err=2, job completes normally.
- Force dec_sym=19 with dec_valid (SYMCHK_EN defined) -> sym_valid not pulsed, next cycle done=1, err=1. Macro undefined -> symbol forwarded.
- No dec_valid for 18 issued bits -> done=1, err=2 the cycle after bit 18.
- rst asserted during SHIFT -> next cycle all outputs at reset values, no done. Then start with sym_count=0 -> done next cycle with busy=0 and no dec_rst pulse.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and symbol-range constants for the Huffman feed sequencer.
package huffman_pkg;

    localparam int SYM_W   = 5;
    localparam int SYM_MIN = 1;
    localparam int SYM_MAX = 18;

    typedef enum logic [1:0] {
        IDLE,
        DRST,
        FETCH,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_LEN   = 2'd2
    } err_t;

endpackage

// File: rtl/huffman_bit_serializer.sv
// Word-to-bit serializer: issues each accepted word MSB-first, and reloads on
// the last bit when a new word is offered so that the bit stream has no gaps.
module huffman_bit_serializer
    import huffman_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  state_t            state,
    input  logic              stop,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load,
    output logic              last_bit,
    output logic              dec_bit,
    output logic              dec_bit_vld
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] shift_q;
    logic [IDX_W-1:0]  bit_idx_q;

    assign dec_bit_vld = (state == SHIFT);
    assign dec_bit     = dec_bit_vld & shift_q[WORD_W-1];
    assign last_bit    = dec_bit_vld && (bit_idx_q == IDX_LAST);
    // Refuse a word in the terminating cycle so nothing is swallowed by a finished job.
    assign in_ready    = !stop && ((state == FETCH) || last_bit);
    assign load        = in_ready && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else if (load) begin
            shift_q   <= in_data;
            bit_idx_q <= '0;
        end else if (dec_bit_vld) begin
            shift_q   <= shift_q << 1;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/huffman_feed_ctrl.sv
// Feeds a packed bitstream into the Huffman decoder and collects sym_count symbols.
// Define HUFF_FEED_SYMCHK_EN to abort on decoded symbols outside SYM_MIN..SYM_MAX.
module huffman_feed_ctrl #(
    parameter int WORD_W   = 8,
    parameter int SYM_W    = 5,
    parameter int CNT_W    = 8,
    parameter int MAX_BITS = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  sym_count,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dec_rst,
    output logic              dec_bit,
    output logic              dec_bit_vld,
    input  logic [SYM_W-1:0]  dec_sym,
    input  logic              dec_valid,
    output logic [SYM_W-1:0]  sym_out,
    output logic              sym_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    import huffman_pkg::*;

    localparam int BITS_W = $clog2(MAX_BITS + 2);
    localparam logic [BITS_W-1:0] BITS_LIM = BITS_W'(MAX_BITS + 1);

    state_t             state_q, state_d;
    err_t               err_q;
    logic [CNT_W-1:0]   target_q, cnt_q;
    logic [BITS_W-1:0]  bits_q, bits_d;
    logic [SYM_W-1:0]   sym_q;
    logic               sym_vld_q, done_q, rst_hold_q;
    logic               active, sym_hit, range_bad, start_ok, start_zero;
    logic               term_range, term_done, term_len, term;
    logic               load, last_bit;

    huffman_bit_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk         (clk),
        .rst         (rst),
        .state       (state_q),
        .stop        (term),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .load        (load),
        .last_bit    (last_bit),
        .dec_bit     (dec_bit),
        .dec_bit_vld (dec_bit_vld)
    );

`ifdef HUFF_FEED_SYMCHK_EN
    localparam logic [SYM_W-1:0] SYM_LO = SYM_W'(SYM_MIN);
    localparam logic [SYM_W-1:0] SYM_HI = SYM_W'(SYM_MAX);
    assign range_bad = (dec_sym < SYM_LO) || (dec_sym > SYM_HI);
`else
    assign range_bad = 1'b0;
`endif

    assign active     = (state_q != IDLE);
    assign sym_hit    = active && dec_valid;
    assign start_ok   = (state_q == IDLE) && start && (sym_count != '0);
    assign start_zero = (state_q == IDLE) && start && (sym_count == '0);

    // A decoded symbol clears the run length even if a bit is issued in the same cycle.
    always_comb begin
        bits_d = bits_q;
        if (sym_hit)
            bits_d = '0;
        else if (dec_bit_vld && (bits_q != BITS_LIM))
            bits_d = bits_q + BITS_W'(1);
    end

    assign term_range = sym_hit && range_bad;
    assign term_done  = sym_hit && !range_bad && ((cnt_q + 1'b1) == target_q);
    assign term_len   = active && (bits_d == BITS_LIM);
    assign term       = term_range || term_done || term_len;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = DRST;
            DRST:    state_d = FETCH;
            FETCH:   if (load) state_d = SHIFT;
            SHIFT:   if (last_bit && !load) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (term)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            target_q   <= '0;
            cnt_q      <= '0;
            bits_q     <= '0;
            sym_q      <= '0;
            sym_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= 1'b0;
            sym_vld_q  <= sym_hit && !range_bad;
            done_q     <= term || start_zero;
            bits_q     <= start_ok ? '0 : bits_d;
            if (sym_hit && !range_bad) begin
                sym_q <= dec_sym;
                cnt_q <= cnt_q + 1'b1;
            end
            if (start_ok || start_zero) begin
                err_q    <= ERR_NONE;
                target_q <= sym_count;
                cnt_q    <= '0;
            end else if (term_range) begin
                err_q <= ERR_RANGE;
            end else if (term_len && !term_done) begin
                err_q <= ERR_LEN;
            end
        end
    end

    assign dec_rst   = rst_hold_q || (state_q == DRST);
    assign busy      = active;
    assign done      = done_q;
    assign sym_out   = sym_q;
    assign sym_valid = sym_vld_q;
    assign err       = err_q;

endmodule

// File: tb/tb_huffman_feed_ctrl.sv
// Directed bench for huffman_feed_ctrl; the decoder core is emulated by driving dec_sym/dec_valid.
module tb_huffman_feed_ctrl;

    localparam int WORD_W   = 8;
    localparam int SYM_W    = 5;
    localparam int CNT_W    = 8;
    localparam int MAX_BITS = 17;

`ifdef HUFF_FEED_SYMCHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  sym_count;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              dec_rst;
    logic              dec_bit;
    logic              dec_bit_vld;
    logic [SYM_W-1:0]  dec_sym;
    logic              dec_valid;
    logic [SYM_W-1:0]  sym_out;
    logic              sym_valid;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    int n_chk = 0;
    int n_err = 0;

    huffman_feed_ctrl #(
        .WORD_W(WORD_W), .SYM_W(SYM_W), .CNT_W(CNT_W), .MAX_BITS(MAX_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sym_count(sym_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dec_rst(dec_rst), .dec_bit(dec_bit), .dec_bit_vld(dec_bit_vld),
        .dec_sym(dec_sym), .dec_valid(dec_valid),
        .sym_out(sym_out), .sym_valid(sym_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_dec_rst"}, dec_rst, 1);
        chk({pfx, "_dec_bit"}, dec_bit, 0);
        chk({pfx, "_dec_bit_vld"}, dec_bit_vld, 0);
        chk({pfx, "_sym_out"}, sym_out, 0);
        chk({pfx, "_sym_valid"}, sym_valid, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_err"}, err, 0);
    endtask

    logic [7:0] exp_a;
    logic [7:0] exp_b;

    initial begin
        rst = 1'b1; start = 1'b0; sym_count = '0; in_data = '0; in_valid = 1'b0;
        dec_sym = '0; dec_valid = 1'b0;

        // Reset values, then release and check dec_rst drops; dec_valid in IDLE is ignored.
        cyc(); cyc(); #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        cyc(); dec_valid = 1'b1; dec_sym = 5'd5; #1;
        chk("rel_dec_rst", dec_rst, 0);
        cyc(); dec_valid = 1'b0; #1;
        chk("idle_sym_ignored", sym_valid, 0);
        chk("idle_busy", busy, 0);

        // Three-symbol decode of 8'b0101_1000.
        exp_a = 8'b0101_1000;
        cyc(); start = 1'b1; sym_count = 8'd3; #1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            start     = 1'b0;
            in_valid  = (c == 2);
            in_data   = 8'h58;
            dec_valid = (c == 5) || (c == 8) || (c == 10);
            dec_sym   = (c == 5) ? 5'd3 : (c == 8) ? 5'd7 : 5'd12;
            #1;
            chk("t1_dec_rst", dec_rst, (c == 1));
            chk("t1_busy", busy, (c <= 10));
            chk("t1_done", done, (c == 11));
            chk("t1_sym_valid", sym_valid, (c == 6) || (c == 9) || (c == 11));
            if (c == 2) chk("t1_in_ready_fetch", in_ready, 1);
            if (c >= 3 && c <= 10) begin
                chk("t1_bit_vld", dec_bit_vld, 1);
                chk("t1_bit", dec_bit, exp_a[10-c]);
            end
            if (c == 6)  chk("t1_sym0", sym_out, 3);
            if (c == 9)  chk("t1_sym1", sym_out, 7);
            if (c == 11) begin
                chk("t1_sym2", sym_out, 12);
                chk("t1_err", err, 0);
                chk("t1_bit_vld_end", dec_bit_vld, 0);
            end
        end

        // Two gapless words, a five-cycle stall, a third word; five symbols incl. 1 and 18.
        exp_a = 8'hA5;
        exp_b = 8'h3C;
        cyc(); start = 1'b1; sym_count = 8'd5; #1;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            start     = 1'b0;
            in_valid  = (c == 2) || (c == 10) || (c == 24);
            in_data   = (c == 2) ? 8'hA5 : (c == 10) ? 8'h3C : 8'hF0;
            dec_valid = (c == 6) || (c == 12) || (c == 17) || (c == 26) || (c == 28);
            dec_sym   = (c == 6) ? 5'd1 : (c == 12) ? 5'd2 : (c == 17) ? 5'd3 :
                        (c == 26) ? 5'd4 : 5'd18;
            #1;
            chk("t2_done", done, (c == 29));
            chk("t2_sym_valid", sym_valid,
                (c == 7) || (c == 13) || (c == 18) || (c == 27) || (c == 29));
            if (c >= 3 && c <= 18) begin
                chk("t2_bit_vld", dec_bit_vld, 1);
                chk("t2_in_ready", in_ready, (c == 10) || (c == 18));
            end
            if (c >= 3 && c <= 10)  chk("t2_bit_a", dec_bit, exp_a[10-c]);
            if (c >= 11 && c <= 18) chk("t2_bit_b", dec_bit, exp_b[18-c]);
            if (c >= 19 && c <= 23) begin
                chk("t3_stall_bit_vld", dec_bit_vld, 0);
                chk("t3_stall_in_ready", in_ready, 1);
                chk("t3_stall_err", err, 0);
                chk("t3_stall_busy", busy, 1);
            end
            if (c >= 25 && c <= 28) chk("t3_bit_vld", dec_bit_vld, 1);
            if (c == 29) begin
                chk("t3_sym_last", sym_out, 18);
                chk("t3_err", err, 0);
                chk("t3_busy", busy, 0);
                chk("t3_bit_vld_end", dec_bit_vld, 0);
            end
        end

        // Symbol 19: aborts with err=1 when the range check is built in, else forwarded.
        cyc(); start = 1'b1; sym_count = 8'd4; #1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            start     = 1'b0;
            in_valid  = (c == 2);
            in_data   = 8'hFF;
            dec_valid = (c == 5);
            dec_sym   = 5'd19;
            #1;
        end
        chk("t4_sym_valid", sym_valid, CHK_EN ? 0 : 1);
        chk("t4_done", done, CHK_EN ? 1 : 0);
        chk("t4_err", err, CHK_EN ? 1 : 0);
        chk("t4_busy", busy, CHK_EN ? 0 : 1);
        chk("t4_sym_out", sym_out, CHK_EN ? 18 : 19);
        cyc(); dec_valid = 1'b0; #1;
        chk("t4_err_hold", err, CHK_EN ? 1 : 0);
        chk("t4_done_pulse", done, 0);
        cyc(); rst = 1'b1; #1;
        cyc(); rst = 1'b0; #1;
        chk_reset_vals("t4_rst");

        // No symbols for 18 issued bits: length abort the cycle after bit 18.
        cyc(); cyc(); start = 1'b1; sym_count = 8'd2; #1;
        for (int c = 1; c <= 22; c++) begin
            cyc();
            start    = 1'b0;
            in_valid = (c == 2) || (c == 10) || (c == 18);
            in_data  = 8'h00;
            #1;
            chk("t5_done", done, (c == 21));
            if (c == 20) chk("t5_bit_vld_18", dec_bit_vld, 1);
            if (c == 21) begin
                chk("t5_err", err, 2);
                chk("t5_busy", busy, 0);
                chk("t5_bit_vld_end", dec_bit_vld, 0);
                chk("t5_in_ready_end", in_ready, 0);
            end
        end

        // Zero-count start: immediate done, no decoder reset, err cleared.
        cyc(); start = 1'b1; sym_count = 8'd0; #1;
        chk("t7_err_held", err, 2);
        cyc(); start = 1'b0; #1;
        chk("t7_done", done, 1);
        chk("t7_busy", busy, 0);
        chk("t7_dec_rst", dec_rst, 0);
        chk("t7_err", err, 0);
        cyc(); #1;
        chk("t7_done_pulse", done, 0);
        chk("t7_dec_rst_after", dec_rst, 0);

        // Reset while shifting: everything back to reset values, no done pulse.
        cyc(); start = 1'b1; sym_count = 8'd3; #1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            start     = 1'b0;
            in_valid  = (c == 2);
            in_data   = 8'hC3;
            dec_valid = (c == 4);
            dec_sym   = 5'd9;
            #1;
        end
        cyc(); dec_valid = 1'b0; rst = 1'b1; #1;
        chk("t6_pre_sym_out", sym_out, 9);
        chk("t6_pre_bit_vld", dec_bit_vld, 1);
        cyc(); rst = 1'b0; #1;
        chk_reset_vals("t6_rst");
        cyc(); #1;
        chk("t6_no_done", done, 0);
        chk("t6_dec_rst_drop", dec_rst, 0);
        chk("t6_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
